// File: rtl/ste_pkg.sv
// Shared types and helpers for the binary-to-BCD converter.
package ste_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} b2b_state_t;

   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned r;
      r = 64'd1;
      for (int unsigned i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/ste_bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module ste_bcd_add3
   import ste_pkg::*;
(
   input  bcd_digit_t din,
   output bcd_digit_t dout
);

   assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/ste_bin2bcd.sv
// Iterative binary-to-BCD converter, one shift-add-3 step per clock, with a
// one-deep pending input register and a one-cycle result strobe.
module ste_bin2bcd
   import ste_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     din_i,
   input  logic                  din_update_i,
   input  logic                  clr_i,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic                  bcd_update_o,
   output logic                  busy_o,
   output logic                  drop_o
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   if (pow10(DIGITS) <= ((64'd1 << DATA_W) - 64'd1)) begin : g_param_err
      $error("ste_bin2bcd: DIGITS too small to represent 2**DATA_W-1");
   end

   b2b_state_t        state_q, state_d;
   logic [DATA_W-1:0] bin_q, bin_d;
   logic [BCD_W-1:0]  work_q, work_d;
   logic [BCD_W-1:0]  corr;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] pend_q, pend_d;
   logic              pend_vld_q, pend_vld_d;
   logic [BCD_W-1:0]  bcd_q, bcd_d;
   logic              upd_q, upd_d;
   logic              busy_q, busy_d;
   logic              drop_q, drop_d;

   for (genvar i = 0; i < DIGITS; i++) begin : g_add3
      ste_bcd_add3 u_add3 (
         .din  (work_q[4*i +: 4]),
         .dout (corr[4*i +: 4])
      );
   end

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      work_d     = work_q;
      cnt_d      = cnt_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      bcd_d      = bcd_q;
      upd_d      = 1'b0;
      drop_d     = 1'b0;

      if (clr_i) begin
         state_d    = IDLE;
         bin_d      = '0;
         work_d     = '0;
         cnt_d      = '0;
         pend_d     = '0;
         pend_vld_d = 1'b0;
         bcd_d      = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (din_update_i) begin
                  bin_d   = din_i;
                  work_d  = '0;
                  cnt_d   = '0;
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               {work_d, bin_d} = {corr, bin_q} << 1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = DONE;
               end
               if (din_update_i) begin
                  drop_d     = pend_vld_q;
                  pend_d     = din_i;
                  pend_vld_d = 1'b1;
               end
            end
            DONE: begin
               bcd_d = work_q;
               upd_d = 1'b1;
               // Pending is older than a same-cycle update, so it converts first.
               if (pend_vld_q) begin
                  bin_d      = pend_q;
                  work_d     = '0;
                  cnt_d      = '0;
                  state_d    = SHIFT;
                  pend_vld_d = din_update_i;
                  if (din_update_i) begin
                     pend_d = din_i;
                  end
               end else if (din_update_i) begin
                  bin_d   = din_i;
                  work_d  = '0;
                  cnt_d   = '0;
                  state_d = SHIFT;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         bin_q      <= '0;
         work_q     <= '0;
         cnt_q      <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         bcd_q      <= '0;
         upd_q      <= 1'b0;
         busy_q     <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         work_q     <= work_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         bcd_q      <= bcd_d;
         upd_q      <= upd_d;
         busy_q     <= busy_d;
         drop_q     <= drop_d;
      end
   end

   assign bcd_o        = bcd_q;
   assign bcd_update_o = upd_q;
   assign busy_o       = busy_q;
   assign drop_o       = drop_q;

endmodule
